// File: rtl/multicycle_control.sv
// multicycle_control: sequencing FSM for a multicycle RV32I core that shares one memory port.
// Steps each instruction through FETCH/DECODE/EXECUTE/(MEMORY)/WRITEBACK. It drives a req/ready
// memory handshake with a wait-state timeout and counts retired instructions.
// Parameter: TIMEOUT_CYCLES (0 disables the memory wait timeout).
// Optional feature macro: MULTICYCLE_ILLEGAL_TRAP_EN. When it is defined, an unlisted opcode
// halts the core; otherwise the opcode retires as a NOP.
// Ports:
//   clock, reset (async, active-low)  inst_opcode[6:0]  mem_ready
//   mem_req/mem_write/mem_addr_select  ir/mdr/pc/regfile write enables
//   alu operand selects, jal/jalr/branch enables, alu_op_type[2:0], reg_writeback_select[2:0]
//   retired_count[31:0], bus_error (sticky timeout flag)

package multicycle_control_pkg;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] ALU_OP_ADD    = 3'd0;
  localparam logic [2:0] ALU_OP_OP     = 3'd1;
  localparam logic [2:0] ALU_OP_OPIMM  = 3'd2;
  localparam logic [2:0] ALU_OP_BRANCH = 3'd3;

  localparam logic [2:0] WB_ALU = 3'd0;
  localparam logic [2:0] WB_MEM = 3'd1;
  localparam logic [2:0] WB_PC4 = 3'd2;
  localparam logic [2:0] WB_IMM = 3'd3;

  // Control word latched in DECODE and held through WRITEBACK.
  typedef struct packed {
    logic       a_sel;
    logic       b_sel;
    logic       jal;
    logic       jalr;
    logic       branch;
    logic       is_load;
    logic       is_store;
    logic       rf_we;
    logic [2:0] alu_op;
    logic [2:0] wb_sel;
  } ctrl_t;

  // Unlisted opcodes decode to all-zero, which is a NOP that writes no register.
  function automatic ctrl_t decode_opcode(input logic [6:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OPC_LUI:    begin c.alu_op = ALU_OP_ADD; c.wb_sel = WB_IMM; c.rf_we = 1'b1; end
      OPC_AUIPC:  begin c.a_sel = 1'b1; c.b_sel = 1'b1; c.alu_op = ALU_OP_ADD;
                        c.wb_sel = WB_ALU; c.rf_we = 1'b1; end
      OPC_JAL:    begin c.a_sel = 1'b1; c.b_sel = 1'b1; c.alu_op = ALU_OP_ADD;
                        c.wb_sel = WB_PC4; c.jal = 1'b1; c.rf_we = 1'b1; end
      OPC_JALR:   begin c.b_sel = 1'b1; c.alu_op = ALU_OP_ADD; c.wb_sel = WB_PC4;
                        c.jalr = 1'b1; c.rf_we = 1'b1; end
      OPC_BRANCH: begin c.alu_op = ALU_OP_BRANCH; c.branch = 1'b1; end
      OPC_LOAD:   begin c.b_sel = 1'b1; c.alu_op = ALU_OP_ADD; c.wb_sel = WB_MEM;
                        c.is_load = 1'b1; c.rf_we = 1'b1; end
      OPC_STORE:  begin c.b_sel = 1'b1; c.alu_op = ALU_OP_ADD; c.is_store = 1'b1; end
      OPC_OPIMM:  begin c.b_sel = 1'b1; c.alu_op = ALU_OP_OPIMM; c.wb_sel = WB_ALU;
                        c.rf_we = 1'b1; end
      OPC_OP:     begin c.alu_op = ALU_OP_OP; c.wb_sel = WB_ALU; c.rf_we = 1'b1; end
      default:    c = '0;
    endcase
    return c;
  endfunction

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  function automatic logic is_legal(input logic [6:0] opcode);
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OPIMM, OPC_OP, OPC_FENCE, OPC_SYSTEM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
`endif
endpackage

module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  inst_opcode,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        mem_addr_select,
  output logic        ir_write_enable,
  output logic        mdr_write_enable,
  output logic        pc_write_enable,
  output logic        regfile_write_enable,
  output logic        alu_operand_a_select,
  output logic        alu_operand_b_select,
  output logic        jal_enable,
  output logic        jalr_enable,
  output logic        branch_enable,
  output logic [2:0]  alu_op_type,
  output logic [2:0]  reg_writeback_select,
  output logic [31:0] retired_count,
  output logic        bus_error
);

  localparam int unsigned WAIT_W     = 8;
  localparam int unsigned CNT_W      = 32;
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_INIT, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_ERROR, S_HALT
  } state_e;

  state_e              state_q, state_d;
  ctrl_t               ctrl_q, ctrl_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                bus_error_q, bus_error_d;
  logic                mem_req_q, mem_req_d;
  logic                addr_sel_q, addr_sel_d;
  logic                mem_write_q, mem_write_d;
  logic                pc_we_q, pc_we_d;
  logic                rf_we_q, rf_we_d;

  // State register and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_INIT;
      ctrl_q      <= '0;
      wait_q      <= '0;
      retired_q   <= '0;
      bus_error_q <= 1'b0;
      mem_req_q   <= 1'b0;
      addr_sel_q  <= 1'b0;
      mem_write_q <= 1'b0;
      pc_we_q     <= 1'b0;
      rf_we_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      wait_q      <= wait_d;
      retired_q   <= retired_d;
      bus_error_q <= bus_error_d;
      mem_req_q   <= mem_req_d;
      addr_sel_q  <= addr_sel_d;
      mem_write_q <= mem_write_d;
      pc_we_q     <= pc_we_d;
      rf_we_q     <= rf_we_d;
    end
  end

  // Next state, control word and next-cycle output values.
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    wait_d    = wait_q;
    retired_d = retired_q;

    case (state_q)
      S_INIT: begin
        state_d = S_FETCH;
        wait_d  = '0;
      end
      S_FETCH, S_MEMORY: begin
        // A ready arriving on the limit cycle still completes the access.
        if (mem_ready) begin
          state_d = (state_q == S_FETCH) ? S_DECODE : S_WRITEBACK;
        end else if (TIMEOUT_EN && (wait_q == WAIT_LIMIT)) begin
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        ctrl_d  = decode_opcode(inst_opcode);
        state_d = S_EXECUTE;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        if (!is_legal(inst_opcode)) state_d = S_HALT;
`endif
      end
      S_EXECUTE: begin
        if (ctrl_q.is_load || ctrl_q.is_store) begin
          state_d = S_MEMORY;
          wait_d  = '0;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        state_d   = S_FETCH;
        wait_d    = '0;
        retired_d = retired_q + CNT_W'(1);
      end
      S_ERROR, S_HALT: state_d = state_q;
      default: state_d = S_INIT;
    endcase

    if (state_d == S_ERROR) ctrl_d = '0;

    mem_req_d   = (state_d == S_FETCH) || (state_d == S_MEMORY);
    addr_sel_d  = (state_d == S_MEMORY);
    mem_write_d = (state_d == S_MEMORY) && ctrl_d.is_store;
    pc_we_d     = (state_d == S_WRITEBACK);
    rf_we_d     = (state_d == S_WRITEBACK) && ctrl_d.rf_we;
    bus_error_d = bus_error_q || (state_d == S_ERROR);
  end

  // Latch strobes must fire in the cycle the memory reports ready.
  assign ir_write_enable  = (state_q == S_FETCH) && mem_ready;
  assign mdr_write_enable = (state_q == S_MEMORY) && mem_ready && ctrl_q.is_load;

  assign mem_req              = mem_req_q;
  assign mem_addr_select      = addr_sel_q;
  assign mem_write            = mem_write_q;
  assign pc_write_enable      = pc_we_q;
  assign regfile_write_enable = rf_we_q;
  assign alu_operand_a_select = ctrl_q.a_sel;
  assign alu_operand_b_select = ctrl_q.b_sel;
  assign jal_enable           = ctrl_q.jal;
  assign jalr_enable          = ctrl_q.jalr;
  assign branch_enable        = ctrl_q.branch;
  assign alu_op_type          = ctrl_q.alu_op;
  assign reg_writeback_select = ctrl_q.wb_sel;
  assign retired_count        = retired_q;
  assign bus_error            = bus_error_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: table of instructions with wait states plus
// hand-written reset-mid-access, timeout and illegal-opcode sequences.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic        clock, reset, mem_ready;
  logic [6:0]  inst_opcode;
  logic        mem_req, mem_write, mem_addr_select, ir_write_enable, mdr_write_enable;
  logic        pc_write_enable, regfile_write_enable, alu_operand_a_select, alu_operand_b_select;
  logic        jal_enable, jalr_enable, branch_enable, bus_error;
  logic [2:0]  alu_op_type, reg_writeback_select;
  logic [31:0] retired_count;

  multicycle_control #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .inst_opcode(inst_opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr_select(mem_addr_select),
    .ir_write_enable(ir_write_enable), .mdr_write_enable(mdr_write_enable),
    .pc_write_enable(pc_write_enable), .regfile_write_enable(regfile_write_enable),
    .alu_operand_a_select(alu_operand_a_select), .alu_operand_b_select(alu_operand_b_select),
    .jal_enable(jal_enable), .jalr_enable(jalr_enable), .branch_enable(branch_enable),
    .alu_op_type(alu_op_type), .reg_writeback_select(reg_writeback_select),
    .retired_count(retired_count), .bus_error(bus_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [50:0] outs;
  assign outs = {mem_req, mem_write, mem_addr_select, ir_write_enable, mdr_write_enable,
                 pc_write_enable, regfile_write_enable, alu_operand_a_select,
                 alu_operand_b_select, jal_enable, jalr_enable, branch_enable,
                 alu_op_type, reg_writeback_select, retired_count, bus_error};

  int n_checks = 0;
  int n_fail   = 0;
  int exp_retired = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [6:0]  opc;
    int          fw;    // fetch wait cycles before ready
    int          mw;    // memory wait cycles before ready
    logic [10:0] ctl;   // {a,b,jal,jalr,branch,alu_op,wb}
    logic        rf;
    logic        ld;
    logic        st;
    int          cyc;
  } vec_t;

  function automatic logic [10:0] mkctl(input logic a, input logic b, input logic jl,
                                        input logic jr, input logic br,
                                        input logic [2:0] alu, input logic [2:0] wb);
    return {a, b, jl, jr, br, alu, wb};
  endfunction

  function automatic vec_t mkv(input logic [6:0] opc, input int fw, input int mw,
                               input logic [10:0] ctl, input logic rf, input logic ld,
                               input logic st, input int cyc);
    vec_t v;
    v.opc = opc; v.fw = fw; v.mw = mw; v.ctl = ctl;
    v.rf = rf; v.ld = ld; v.st = st; v.cyc = cyc;
    return v;
  endfunction

  // Runs one instruction starting at a negedge in FETCH; ends at the negedge back in FETCH.
  task automatic run_instr(input vec_t v);
    int fw_cnt = 0, mw_cnt = 0, ir_cnt = 0, ir_at = 0, pc_at = 0, rf_cnt = 0;
    int mdr_cnt = 0, mw_ok = 0, mw_bad = 0, mreq_mem = 0;
    logic [10:0] ctl_wb = '0;
    bit done = 1'b0;
    string tag;
    tag = $sformatf("op%02h_fw%0d_mw%0d", v.opc, v.fw, v.mw);
    inst_opcode = v.opc;
    for (int k = 1; k <= 40 && !done; k++) begin
      if (mem_req) mem_ready = mem_addr_select ? (mw_cnt == v.mw) : (fw_cnt == v.fw);
      else mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (ir_write_enable) begin ir_cnt++; ir_at = k; end
      if (mdr_write_enable) mdr_cnt++;
      if (regfile_write_enable) rf_cnt++;
      if (mem_write) begin
        if (mem_req && mem_addr_select) mw_ok++;
        else mw_bad++;
      end
      if (mem_req && mem_addr_select) mreq_mem++;
      if (mem_req && !mem_ready) begin
        if (mem_addr_select) mw_cnt++;
        else fw_cnt++;
      end
      if (pc_write_enable) begin
        pc_at  = k;
        ctl_wb = {alu_operand_a_select, alu_operand_b_select, jal_enable, jalr_enable,
                  branch_enable, alu_op_type, reg_writeback_select};
        done   = 1'b1;
      end
      @(negedge clock);
    end
    if (done) exp_retired++;
    check({tag, "_completed"}, 64'(done), 64'd1);
    check({tag, "_cycles"}, 64'(pc_at), 64'(v.cyc));
    check({tag, "_ir_cycle"}, 64'(ir_at), 64'(v.fw + 1));
    check({tag, "_ir_count"}, 64'(ir_cnt), 64'd1);
    check({tag, "_rf_count"}, 64'(rf_cnt), 64'(v.rf));
    check({tag, "_mdr_count"}, 64'(mdr_cnt), 64'(v.ld));
    check({tag, "_memwrite_cycles"}, 64'(mw_ok), v.st ? 64'(v.mw + 1) : 64'd0);
    check({tag, "_memwrite_outside"}, 64'(mw_bad), 64'd0);
    check({tag, "_memreq_cycles"}, 64'(mreq_mem), (v.ld || v.st) ? 64'(v.mw + 1) : 64'd0);
    check({tag, "_ctl"}, 64'(ctl_wb), 64'(v.ctl));
    check({tag, "_retired"}, 64'(retired_count), 64'(exp_retired));
    check({tag, "_back_to_fetch"}, 64'({mem_req, mem_addr_select, pc_write_enable}), 64'b100);
  endtask

  vec_t vecs[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs.push_back(mkv(OPC_OPIMM,  0, 0, mkctl(0,1,0,0,0,ALU_OP_OPIMM, WB_ALU), 1, 0, 0, 4));
    vecs.push_back(mkv(OPC_LUI,    1, 0, mkctl(0,0,0,0,0,ALU_OP_ADD,   WB_IMM), 1, 0, 0, 5));
    vecs.push_back(mkv(OPC_AUIPC,  0, 0, mkctl(1,1,0,0,0,ALU_OP_ADD,   WB_ALU), 1, 0, 0, 4));
    vecs.push_back(mkv(OPC_JAL,    0, 0, mkctl(1,1,1,0,0,ALU_OP_ADD,   WB_PC4), 1, 0, 0, 4));
    vecs.push_back(mkv(OPC_JALR,   2, 0, mkctl(0,1,0,1,0,ALU_OP_ADD,   WB_PC4), 1, 0, 0, 6));
    vecs.push_back(mkv(OPC_BRANCH, 0, 0, mkctl(0,0,0,0,1,ALU_OP_BRANCH,WB_ALU), 0, 0, 0, 4));
    vecs.push_back(mkv(OPC_OP,     0, 0, mkctl(0,0,0,0,0,ALU_OP_OP,    WB_ALU), 1, 0, 0, 4));
    vecs.push_back(mkv(OPC_LOAD,   0, 3, mkctl(0,1,0,0,0,ALU_OP_ADD,   WB_MEM), 1, 1, 0, 8));
    vecs.push_back(mkv(OPC_STORE,  0, 0, mkctl(0,1,0,0,0,ALU_OP_ADD,   WB_ALU), 0, 0, 1, 5));
    vecs.push_back(mkv(OPC_STORE,  3, 3, mkctl(0,1,0,0,0,ALU_OP_ADD,   WB_ALU), 0, 0, 1, 11));
    vecs.push_back(mkv(OPC_LOAD,   0, 0, mkctl(0,1,0,0,0,ALU_OP_ADD,   WB_MEM), 1, 1, 0, 5));
    vecs.push_back(mkv(OPC_FENCE,  0, 0, 11'd0, 0, 0, 0, 4));
    vecs.push_back(mkv(OPC_SYSTEM, 0, 1, 11'd0, 0, 0, 0, 4));

    // Power-on reset.
    reset = 1'b1; mem_ready = 1'b0; inst_opcode = 7'd0;
    #1 reset = 1'b0;
    #3 check("reset_outputs", 64'(outs), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    mem_ready = 1'b1;
    #1 check("init_no_strobes", 64'(outs), 64'd0);
    mem_ready = 1'b0;
    @(negedge clock);
    check("first_fetch", 64'({mem_req, mem_addr_select, mem_write}), 64'b100);

    for (int i = 0; i < vecs.size(); i++) run_instr(vecs[i]);

    // Reset asserted while a load waits in MEMORY.
    inst_opcode = OPC_LOAD;
    mem_ready = 1'b1;
    @(negedge clock);
    mem_ready = 1'b0;
    for (int g = 0; g < 10 && !(mem_req && mem_addr_select); g++) @(negedge clock);
    check("mid_mem_reached", 64'(mem_req && mem_addr_select), 64'd1);
    @(negedge clock);
    #2 reset = 1'b0;
    #1 check("mid_mem_reset_outputs", 64'(outs), 64'd0);
    mem_ready = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    #1 check("mid_mem_init", 64'(outs), 64'd0);
    mem_ready = 1'b0;
    exp_retired = 0;

    // Fetch never answered: four wait cycles then ERROR.
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      #1 check($sformatf("timeout_fetch_cycle%0d", c),
               64'({mem_req, mem_addr_select, ir_write_enable, bus_error}), 64'b1000);
    end
    @(negedge clock);
    #1 check("timeout_error_entry", 64'({mem_req, bus_error}), 64'b01);
    for (int c = 0; c < 8; c++) begin
      mem_ready = 1'($urandom_range(0, 1));
      #1 check($sformatf("error_hold%0d", c),
               64'({mem_req, ir_write_enable, pc_write_enable, regfile_write_enable,
                    mdr_write_enable, bus_error}), 64'b000001);
      @(negedge clock);
    end
    check("error_retired", 64'(retired_count), 64'd0);
    reset = 1'b0;
    #1 check("error_cleared_by_reset", 64'(outs), 64'd0);
    mem_ready = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Unlisted opcode 7'h7F.
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    inst_opcode = 7'h7F;
    mem_ready = 1'b1;
    #1 check("illegal_fetch_ir", 64'(ir_write_enable), 64'd1);
    @(negedge clock);
    for (int c = 0; c < 10; c++) begin
      mem_ready = 1'($urandom_range(0, 1));
      #1 check($sformatf("halt_hold%0d", c),
               64'({mem_req, ir_write_enable, pc_write_enable, regfile_write_enable,
                    mdr_write_enable}), 64'd0);
      @(negedge clock);
    end
    check("halt_retired_frozen", 64'(retired_count), 64'd0);
`else
    run_instr(mkv(7'h7F, 0, 0, 11'd0, 0, 0, 0, 4));
    check("illegal_nop_retired", 64'(retired_count), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
